// File: rtl/qam_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qam_tx_pkg
// Description : Shared types and constants for the QAM-16 transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package qam_tx_pkg;

    localparam int QAM_SPS = 11;
    localparam int SYM_W   = 4;
    localparam int ENTRY_W = 2 * SYM_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic             last;
        logic [SYM_W-1:0] i;
        logic [SYM_W-1:0] q;
    } sym_entry_t;

endpackage
`default_nettype wire

// File: rtl/sym_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sym_fifo
// Description : Synchronous FIFO, show-ahead read port, wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_one = (AW + 1)'(1);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_one;
            if (w_pop)  r_rptr <= r_rptr + c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rptr[AW-1:0]];
    assign empty = (r_wptr == r_rptr);
    // Same slot index but opposite wrap bit means the writer has lapped the reader.
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/qam_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : qam_tx_scheduler
// Description : Holds each QAM-16 symbol for one symbol period in front of a
//               zero-stuffing upsampler, aligning its phase to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module qam_tx_scheduler
    import qam_tx_pkg::*;
#(
    parameter int SPS        = QAM_SPS,
    parameter int DEPTH      = 4,
    parameter int FLUSH_SYMS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_en,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    input  logic signed [SYM_W-1:0] sym_i,
    input  logic signed [SYM_W-1:0] sym_q,
    input  logic                    sym_last,
    output logic signed [SYM_W-1:0] iout,
    output logic signed [SYM_W-1:0] qout,
    output logic                    up_reset,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    underrun,
    output logic [7:0]              underrun_cnt,
    input  logic                    clr_underrun
);

    localparam int PH_W = $clog2(SPS);
    localparam int FC_W = (FLUSH_SYMS > 1) ? $clog2(FLUSH_SYMS) : 1;
    localparam logic [PH_W-1:0] c_ph_last = PH_W'(SPS - 1);
    localparam logic [PH_W-1:0] c_ph_one  = PH_W'(1);
    localparam logic [FC_W-1:0] c_fc_last = FC_W'((FLUSH_SYMS > 0) ? FLUSH_SYMS - 1 : 0);
    localparam logic [FC_W-1:0] c_fc_one  = FC_W'(1);

    state_t                  r_state, w_state_nx;
    logic [PH_W-1:0]         r_ph, w_ph_nx;
    logic [FC_W-1:0]         r_fcnt, w_fcnt_nx;
    logic                    r_cur_last, w_cur_last_nx;
    logic signed [SYM_W-1:0] r_iout, w_iout_nx;
    logic signed [SYM_W-1:0] r_qout, w_qout_nx;
    logic                    r_up_reset, w_up_reset_nx;
    logic                    r_frame_done, w_frame_done_nx;
    logic                    r_underrun, w_underrun_nx;
    logic [7:0]              r_ur_cnt, w_ur_cnt_nx;

    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_ph_wrap;
    logic [ENTRY_W-1:0]      w_dout;
    sym_entry_t              w_head;

    sym_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sym_valid),
        .din   ({sym_last, sym_i, sym_q}),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_head    = sym_entry_t'(w_dout);
    assign w_ph_wrap = (r_ph == c_ph_last);

    always_comb begin
        w_state_nx      = r_state;
        w_ph_nx         = r_ph;
        w_fcnt_nx       = r_fcnt;
        w_cur_last_nx   = r_cur_last;
        w_iout_nx       = r_iout;
        w_qout_nx       = r_qout;
        w_up_reset_nx   = r_up_reset;
        w_frame_done_nx = 1'b0;
        w_underrun_nx   = r_underrun;
        w_ur_cnt_nx     = r_ur_cnt;
        w_pop           = 1'b0;

        case (r_state)
            IDLE: begin
                w_ph_nx       = '0;
                w_iout_nx     = '0;
                w_qout_nx     = '0;
                w_up_reset_nx = 1'b1;
                if (tx_en && !w_empty) begin
                    w_pop         = 1'b1;
                    w_iout_nx     = w_head.i;
                    w_qout_nx     = w_head.q;
                    w_cur_last_nx = w_head.last;
                    w_up_reset_nx = 1'b0;
                    w_state_nx    = RUN;
                end
            end
            RUN: begin
                w_ph_nx = w_ph_wrap ? '0 : r_ph + c_ph_one;
                // Every new value lands on the edge before the upsampler's capture cycle.
                if (w_ph_wrap) begin
                    if (r_cur_last) begin
                        w_iout_nx     = '0;
                        w_qout_nx     = '0;
                        w_cur_last_nx = 1'b0;
                        w_fcnt_nx     = '0;
                        if (FLUSH_SYMS == 0) begin
                            w_up_reset_nx   = 1'b1;
                            w_frame_done_nx = 1'b1;
                            w_state_nx      = IDLE;
                        end else begin
                            w_state_nx = FLUSH;
                        end
                    end else if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_iout_nx     = w_head.i;
                        w_qout_nx     = w_head.q;
                        w_cur_last_nx = w_head.last;
                    end else begin
                        w_iout_nx     = '0;
                        w_qout_nx     = '0;
                        w_underrun_nx = 1'b1;
                        if (r_ur_cnt != 8'hFF) w_ur_cnt_nx = r_ur_cnt + 8'd1;
                    end
                end
            end
            FLUSH: begin
                w_ph_nx = w_ph_wrap ? '0 : r_ph + c_ph_one;
                if (w_ph_wrap) begin
                    if (r_fcnt == c_fc_last) begin
                        w_up_reset_nx   = 1'b1;
                        w_frame_done_nx = 1'b1;
                        w_state_nx      = IDLE;
                    end else begin
                        w_fcnt_nx = r_fcnt + c_fc_one;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase

        if (clr_underrun) begin
            w_underrun_nx = 1'b0;
            w_ur_cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_ph         <= '0;
            r_fcnt       <= '0;
            r_cur_last   <= 1'b0;
            r_iout       <= '0;
            r_qout       <= '0;
            r_up_reset   <= 1'b1;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_ur_cnt     <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_ph         <= w_ph_nx;
            r_fcnt       <= w_fcnt_nx;
            r_cur_last   <= w_cur_last_nx;
            r_iout       <= w_iout_nx;
            r_qout       <= w_qout_nx;
            r_up_reset   <= w_up_reset_nx;
            r_frame_done <= w_frame_done_nx;
            r_underrun   <= w_underrun_nx;
            r_ur_cnt     <= w_ur_cnt_nx;
        end
    end

    assign sym_ready    = ~w_full;
    assign iout         = r_iout;
    assign qout         = r_qout;
    assign up_reset     = r_up_reset;
    assign busy         = (r_state != IDLE);
    assign frame_done   = r_frame_done;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ur_cnt;

endmodule
`default_nettype wire
